wire_alu_core: RTL and testbench

WIRE_ALU_CORE -- requirements
Module: wire_alu_core

---
 rtl/wire_alu_core.sv | 167 ++++++++++++++++
 tb/tb_wire_alu_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wire_alu_core.sv
// Host-driven ALU core: captures a command on start, runs logic/add/sub in one
// EXEC cycle or a shift-add multiply in MUL, then reports in a one-cycle DONE.
module wire_alu_core #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LED_N = 4
) (
   input  logic             okClk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [15:0]      op_count,
   output logic [LED_N-1:0] led
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] mul_hi_q, mul_hi_d;
   logic [WIDTH-1:0] mul_lo_q, mul_lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [15:0]      op_count_q, op_count_d;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH:0]   mul_sum;

   always_comb begin
      add_sum  = {1'b0, a_q} + {1'b0, b_q};
      sub_diff = {1'b0, a_q} - {1'b0, b_q};
      mul_sum  = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, a_q} : '0);

      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      mul_hi_d    = mul_hi_q;
      mul_lo_d    = mul_lo_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      op_count_d  = op_count_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op;
               a_d      = data0;
               b_d      = data1;
               mul_hi_d = '0;
               mul_lo_d = data1;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = (op == 3'd5) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            err_d       = 1'b0;
            result_hi_d = '0;
            case (op_q)
               3'd0: result_d = a_q & b_q;
               3'd1: result_d = a_q | b_q;
               3'd2: result_d = a_q ^ b_q;
               3'd3: begin
                  result_d    = add_sum[WIDTH-1:0];
                  result_hi_d = WIDTH'(add_sum[WIDTH]);
               end
               3'd4: begin
                  // Top bit of the widened difference is the unsigned borrow.
                  result_d    = sub_diff[WIDTH-1:0];
                  result_hi_d = WIDTH'(sub_diff[WIDTH]);
               end
               default: begin
                  result_d = '0;
                  err_d    = 1'b1;
               end
            endcase
            done_d     = 1'b1;
            op_count_d = op_count_q + 16'd1;
            state_d    = S_DONE;
         end
         S_MUL: begin
            // WIDTH shift-add steps, then one cycle to publish the product.
            if (cnt_q != CNT_W'(WIDTH)) begin
               mul_hi_d = mul_sum[WIDTH:1];
               mul_lo_d = {mul_sum[0], mul_lo_q[WIDTH-1:1]};
               cnt_d    = cnt_q + 1'b1;
            end else begin
               result_d    = mul_lo_q;
               result_hi_d = mul_hi_q;
               err_d       = 1'b0;
               done_d      = 1'b1;
               op_count_d  = op_count_q + 16'd1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge okClk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mul_hi_q    <= '0;
         mul_lo_q    <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         mul_hi_q    <= mul_hi_d;
         mul_lo_q    <= mul_lo_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         op_count_q  <= op_count_d;
      end
   end

   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign op_count  = op_count_q;

   for (genvar i = 0; i < LED_N; i++) begin : g_led
      assign led[i] = result_q[i] ? 1'b0 : 1'bz;
   end

endmodule

// File: tb/tb_wire_alu_core.sv
// Randomized bench for wire_alu_core (32-bit and 8-bit instances) against an
// arithmetic reference model; LED pins are pulled up so high-Z reads as 1.
module tb_wire_alu_core;

   logic okClk = 1'b0;
   always #5 okClk = ~okClk;

   logic        rst_n, start, sel8;
   logic [2:0]  op;
   logic [63:0] d0, d1;
   logic        start32, start8;

   logic [31:0] res32, hi32;
   logic        busy32, done32, err32;
   logic [15:0] cnt32;
   wire  [3:0]  led32;

   logic [7:0]  res8, hi8;
   logic        busy8, done8, err8;
   logic [15:0] cnt8;
   wire  [1:0]  led8;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [15:0] cnt_m32, cnt_m8;

   assign start32 = start & ~sel8;
   assign start8  = start & sel8;

   for (genvar g = 0; g < 4; g++) begin : g_pu32
      pullup pu (led32[g]);
   end
   for (genvar g = 0; g < 2; g++) begin : g_pu8
      pullup pu (led8[g]);
   end

   wire_alu_core #(.WIDTH(32), .LED_N(4)) u_dut32 (
      .okClk(okClk), .rst_n(rst_n), .start(start32), .op(op),
      .data0(d0[31:0]), .data1(d1[31:0]), .result(res32), .result_hi(hi32),
      .busy(busy32), .done(done32), .err(err32), .op_count(cnt32), .led(led32)
   );

   wire_alu_core #(.WIDTH(8), .LED_N(2)) u_dut8 (
      .okClk(okClk), .rst_n(rst_n), .start(start8), .op(op),
      .data0(d0[7:0]), .data1(d1[7:0]), .result(res8), .result_hi(hi8),
      .busy(busy8), .done(done8), .err(err8), .op_count(cnt8), .led(led8)
   );

   logic [63:0] obs_res, obs_hi;
   logic        obs_busy, obs_done, obs_err;
   logic [15:0] obs_cnt;
   logic [3:0]  obs_led;

   assign obs_res  = sel8 ? {56'd0, res8} : {32'd0, res32};
   assign obs_hi   = sel8 ? {56'd0, hi8}  : {32'd0, hi32};
   assign obs_busy = sel8 ? busy8 : busy32;
   assign obs_done = sel8 ? done8 : done32;
   assign obs_err  = sel8 ? err8  : err32;
   assign obs_cnt  = sel8 ? cnt8  : cnt32;
   assign obs_led  = sel8 ? {2'b00, led8} : led32;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model(input logic [2:0] o, input logic [63:0] a_in, input logic [63:0] b_in,
                        input int unsigned w, output logic [63:0] lo, output logic [63:0] hi,
                        output logic e, output int unsigned lat);
      logic [63:0] mask, a, b, t;
      mask = (64'd1 << w) - 64'd1;
      a    = a_in & mask;
      b    = b_in & mask;
      lo   = '0;
      hi   = '0;
      e    = 1'b0;
      lat  = 2;
      case (o)
         3'd0: lo = a & b;
         3'd1: lo = a | b;
         3'd2: lo = a ^ b;
         3'd3: begin t = a + b; lo = t & mask; hi = t >> w; end
         3'd4: begin lo = (a - b) & mask; hi = (a < b) ? 64'd1 : 64'd0; end
         3'd5: begin t = a * b; lo = t & mask; hi = t >> w; lat = w + 2; end
         default: e = 1'b1;
      endcase
   endtask

   function automatic logic [63:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'd1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic noise();
      start = 1'($urandom_range(0, 1));
      op    = 3'($urandom);
      d0    = {$urandom, $urandom};
      d1    = {$urandom, $urandom};
   endtask

   task automatic run_cmd(input bit s8, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] e_lo, e_hi;
      logic        e_err;
      logic [15:0] e_cnt;
      logic [3:0]  e_led;
      int unsigned e_lat, cyc;
      model(o, a, b, s8 ? 8 : 32, e_lo, e_hi, e_err, e_lat);
      if (s8) begin cnt_m8++;  e_cnt = cnt_m8;  end
      else    begin cnt_m32++; e_cnt = cnt_m32; end
      e_led = s8 ? {2'b00, ~e_lo[1:0]} : ~e_lo[3:0];

      @(negedge okClk);
      sel8 = s8; op = o; d0 = a; d1 = b; start = 1'b1;
      @(posedge okClk); @(negedge okClk);
      cyc = 1;
      check("busy_after_start", obs_busy, 1);
      while (obs_done !== 1'b1 && cyc < 200) begin
         noise();
         @(posedge okClk); @(negedge okClk);
         cyc++;
      end
      check("latency", cyc, e_lat);
      check("result", obs_res, e_lo);
      check("result_hi", obs_hi, e_hi);
      check("err", obs_err, e_err);
      check("op_count", obs_cnt, e_cnt);
      check("busy_in_done", obs_busy, 1);
      check("led", obs_led, e_led);

      noise();
      @(posedge okClk); @(negedge okClk);
      check("done_pulse_width", obs_done, 0);
      check("busy_after_done", obs_busy, 0);
      check("result_hold", obs_res, e_lo);
      check("result_hi_hold", obs_hi, e_hi);
      check("err_hold", obs_err, e_err);
      check("op_count_hold", obs_cnt, e_cnt);
      start = 1'b0;
   endtask

   task automatic check_reset_state();
      check("rst_result32", res32, 0);
      check("rst_hi32", hi32, 0);
      check("rst_busy32", busy32, 0);
      check("rst_done32", done32, 0);
      check("rst_err32", err32, 0);
      check("rst_cnt32", cnt32, 0);
      check("rst_led32", led32, 4'hF);
      check("rst_result8", res8, 0);
      check("rst_hi8", hi8, 0);
      check("rst_busy8", busy8, 0);
      check("rst_cnt8", cnt8, 0);
      check("rst_led8", led8, 2'b11);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_done;
      rst_n = 1'b0; start = 1'b0; sel8 = 1'b0; op = '0; d0 = '0; d1 = '0;
      cnt_m32 = '0; cnt_m8 = '0;
      repeat (3) @(posedge okClk);
      @(negedge okClk);
      check_reset_state();
      rst_n = 1'b1;

      run_cmd(1'b0, 3'd3, 64'hFFFF_FFFF, 64'h1);
      run_cmd(1'b0, 3'd5, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      run_cmd(1'b0, 3'd4, 64'd3, 64'd5);
      run_cmd(1'b0, 3'd7, 64'h1234, 64'h5678);
      run_cmd(1'b0, 3'd1, 64'h5, 64'hA);
      run_cmd(1'b1, 3'd5, 64'hFF, 64'h02);
      run_cmd(1'b1, 3'd6, 64'hFF, 64'hFF);

      for (int i = 0; i < 60; i++)
         run_cmd(1'($urandom_range(0, 1)), 3'($urandom), rand_opnd(), rand_opnd());

      // Abort a multiply with reset on its 10th MUL cycle, start held high.
      @(negedge okClk);
      sel8 = 1'b0; op = 3'd5; d0 = 64'hFFFF_FFFF; d1 = 64'hDEAD_BEEF; start = 1'b1;
      @(posedge okClk); @(negedge okClk);
      start = 1'b0;
      repeat (9) begin @(posedge okClk); @(negedge okClk); end
      rst_n = 1'b0; start = 1'b1; op = 3'd0;
      @(posedge okClk); @(negedge okClk);
      check_reset_state();
      rst_n = 1'b1; start = 1'b0;
      cnt_m32 = '0; cnt_m8 = '0;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge okClk); @(negedge okClk);
         if (done32 === 1'b1 || busy32 === 1'b1) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);
      run_cmd(1'b0, 3'd0, 64'hF0, 64'h3C);

      // Preload the counter next to its wrap point.
      @(negedge okClk);
      force u_dut32.op_count_q = 16'hFFFE;
      @(posedge okClk); @(negedge okClk);
      release u_dut32.op_count_q;
      cnt_m32 = 16'hFFFE;
      run_cmd(1'b0, 3'($urandom_range(0, 4)), rand_opnd(), rand_opnd());
      run_cmd(1'b0, 3'd6, rand_opnd(), rand_opnd());

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
